// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: instruction-memory bus between the fetch stage and the ROM.
//   i_addr  : byte address driven by the fetch stage (master)
//   i_rdata : instruction word returned by the asynchronous-read ROM (slave)
interface if_fetch_stage_if;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    modport master (output i_addr, input i_rdata);
    modport slave (input i_addr, output i_rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: MIPS instruction-fetch stage with fetch PC and IF/ID register.
//   clk, reset     : clock and synchronous active-high reset
//   stall          : freezes F_pc and IF/ID
//   flush          : turns IF/ID into a bubble (wins over stall)
//   redirect_valid : load redirect_pc as the next F_pc
//   redirect_pc    : branch/jump target, used unmasked
//   imem           : instruction-memory bus (i_addr = F_pc, i_rdata same cycle)
//   F_pc           : current fetch PC
//   D_instr/D_pc   : IF/ID instruction word and its PC
//   D_valid/D_exc  : IF/ID real-instruction flag and fetch-exception flag
//   fetch_count    : valid IF/ID loads since reset
// Optional: define FETCH_EXC_EN to flag misaligned or out-of-ROM fetches.
module if_fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int          IM_WORDS = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    if_fetch_stage_if.master  imem,
    output logic [31:0]       F_pc,
    output logic [31:0]       D_instr,
    output logic [31:0]       D_pc,
    output logic              D_valid,
    output logic              D_exc,
    output logic [31:0]       fetch_count
);
`ifdef FETCH_EXC_EN
    localparam logic EXC_EN = 1'b1;
`else
    localparam logic EXC_EN = 1'b0;
`endif
    // 33-bit end address so a ROM ending at the top of memory does not wrap.
    localparam logic [32:0] IM_END = {1'b0, IM_BASE} + 33'(4 * IM_WORDS);
    logic [31:0] next_pc;
    logic        fetch_exc;
    assign imem.i_addr = F_pc;
    always_comb begin
        next_pc   = redirect_valid ? redirect_pc : F_pc + 32'd4;
        fetch_exc = EXC_EN && ((|F_pc[1:0]) || (F_pc < IM_BASE) || ({1'b0, F_pc} >= IM_END));
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            F_pc        <= PC_RESET;
            D_instr     <= '0;
            D_pc        <= '0;
            D_valid     <= 1'b0;
            D_exc       <= 1'b0;
            fetch_count <= '0;
        end else begin
            if (!stall) F_pc <= next_pc;
            if (flush) begin
                D_instr <= '0;
                D_pc    <= '0;
                D_valid <= 1'b0;
                D_exc   <= 1'b0;
            end else if (!stall) begin
                D_instr     <= fetch_exc ? 32'd0 : imem.i_rdata;
                D_pc        <= F_pc;
                D_valid     <= 1'b1;
                D_exc       <= fetch_exc;
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: scoreboard bench for if_fetch_stage with a behavioural ROM.
module tb_if_fetch_stage;
    logic        clk = 1'b0;
    logic        reset, stall, flush, redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] F_pc, D_instr, D_pc, fetch_count;
    logic        D_valid, D_exc;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [31:0] pc, instr, dpc, cnt;
        logic        v, e;
    } exp_t;
    exp_t sb[$];

    logic [31:0] m_pc, m_instr, m_dpc, m_cnt;
    logic        m_v, m_e;

`ifdef FETCH_EXC_EN
    localparam logic EXC = 1'b1;
`else
    localparam logic EXC = 1'b0;
`endif

    if_fetch_stage_if imem ();

    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a == 32'h3000) return 32'h3C01_0001;
        if (a == 32'h3004) return 32'h3421_0002;
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign imem.i_rdata = rom(imem.i_addr);

    if_fetch_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem(imem), .F_pc(F_pc), .D_instr(D_instr), .D_pc(D_pc),
        .D_valid(D_valid), .D_exc(D_exc), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, push the expected post-edge state, then compare.
    task automatic step(input logic r, input logic st, input logic fl,
                        input logic rv, input logic [31:0] rpc);
        exp_t e;
        logic bad;
        @(negedge clk);
        reset = r; stall = st; flush = fl; redirect_valid = rv; redirect_pc = rpc;
        if (r) begin
            m_pc = 32'h3000; m_instr = 0; m_dpc = 0; m_v = 0; m_e = 0; m_cnt = 0;
        end else begin
            bad = EXC && (m_pc[1:0] != 2'b00 || m_pc < 32'h3000 || m_pc >= 32'h7000);
            if (fl) begin
                m_instr = 0; m_dpc = 0; m_v = 0; m_e = 0;
            end else if (!st) begin
                m_instr = bad ? 32'd0 : rom(m_pc);
                m_dpc = m_pc; m_v = 1; m_e = bad; m_cnt = m_cnt + 1;
            end
            if (!st) m_pc = rv ? rpc : m_pc + 32'd4;
        end
        e.pc = m_pc; e.instr = m_instr; e.dpc = m_dpc; e.cnt = m_cnt; e.v = m_v; e.e = m_e;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("F_pc", F_pc, e.pc);
        check("D_instr", D_instr, e.instr);
        check("D_pc", D_pc, e.dpc);
        check("D_valid", {31'd0, D_valid}, {31'd0, e.v});
        check("D_exc", {31'd0, D_exc}, {31'd0, e.e});
        check("fetch_count", fetch_count, e.cnt);
        check("i_addr", imem.i_addr, F_pc);
    endtask

    initial begin
        reset = 1; stall = 0; flush = 0; redirect_valid = 0; redirect_pc = 0;
        step(1, 0, 0, 0, 0);
        check("rst_pc", F_pc, 32'h3000);
        check("rst_cnt", fetch_count, 0);
        step(0, 0, 0, 0, 0);
        check("tp_instr0", D_instr, 32'h3C01_0001);
        step(0, 0, 0, 0, 0);
        check("tp_instr1", D_instr, 32'h3421_0002);
        check("tp_dpc1", D_pc, 32'h3004);
        check("tp_cnt2", fetch_count, 2);
        check("tp_pc", F_pc, 32'h3008);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 32'h5000);
        check("stall_pc", F_pc, 32'h3008);
        check("stall_cnt", fetch_count, 2);
        step(0, 0, 0, 0, 0);
        check("release_pc", F_pc, 32'h300C);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h3040);
        check("redir_pc", F_pc, 32'h3040);
        check("delay_slot_dpc", D_pc, 32'h3010);
        step(0, 0, 0, 1, 32'h3020);
        step(0, 1, 1, 0, 0);
        check("fl_st_pc", F_pc, 32'h3020);
        check("fl_st_valid", {31'd0, D_valid}, 0);
        step(0, 0, 1, 1, 32'h3100);
        check("fl_redir_pc", F_pc, 32'h3100);
        step(0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 32'h4000);
        check("midrst_pc", F_pc, 32'h3000);
        step(0, 0, 0, 1, 32'h3002);
        step(0, 0, 0, 0, 0);
        check("exc_dpc", D_pc, 32'h3002);
        check("exc_flag", {31'd0, D_exc}, {31'd0, EXC});
        step(0, 0, 0, 1, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 0);
        check("wrap_pc", F_pc, 32'h0);
        step(0, 0, 0, 1, 32'h6FFC);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            logic [31:0] t;
            t = $urandom_range(3, 0) == 0 ? $urandom : 32'h3000 + ($urandom_range(4095, 0) << 2);
            step($urandom_range(40, 0) == 0, $urandom_range(3, 0) == 0,
                 $urandom_range(4, 0) == 0, $urandom_range(3, 0) == 0, t);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
